mult_div_unit: RTL and testbench

- Multi-cycle signed multiply/divide unit for the multicycle MIPS datapath.
- Executes mult and div and holds the HI/LO architectural registers.
- HI and LO outputs feed the HI and LO inputs of the writeback select mux (MemToReg codes 3'b100 and 3'b101), so mfhi/mflo read them directly.
- Control unit starts an operation and stalls on Busy until Done.

---
 rtl/mult_div_unit.sv | 177 +++++++++++++++++
 tb/tb_mult_div_unit.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mult_div_unit.sv
// Multi-cycle signed multiply/divide unit holding the HI/LO registers.
// Radix-2 Booth multiply and restoring divide, one iteration per clock.
module mult_div_unit #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] A,
    input  logic [DATA_W-1:0] B,
    input  logic              MultStart,
    input  logic              DivStart,
    output logic [DATA_W-1:0] HI,
    output logic [DATA_W-1:0] LO,
    output logic              Busy,
    output logic              Done,
    output logic              DivZero
);

    localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam int ACC_W = 2 * DATA_W + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_MULT,
        S_DIV,
        S_DONE
    } state_t;

    state_t r_state;
    state_t w_next;

    logic [CNT_W-1:0]  r_cnt;
    logic [ACC_W-1:0]  r_acc;      // {partial high word, multiplier, Booth q-1 bit}
    logic [DATA_W-1:0] r_mcand;
    logic [DATA_W-1:0] r_rem;
    logic [DATA_W-1:0] r_quo;
    logic [DATA_W-1:0] r_divisor;
    logic              r_negq;
    logic              r_negr;
    logic [DATA_W-1:0] r_hi;
    logic [DATA_W-1:0] r_lo;
    logic              r_divzero;

    logic              w_last;
    logic [DATA_W-1:0] w_abs_a;
    logic [DATA_W-1:0] w_abs_b;
    logic [DATA_W:0]   w_booth_hi;
    logic [DATA_W:0]   w_mcand_x;
    logic [DATA_W:0]   w_booth_sum;
    logic [ACC_W-1:0]  w_acc_next;
    logic [DATA_W:0]   w_shift;
    logic [DATA_W:0]   w_trial;
    logic              w_fits;
    logic [DATA_W-1:0] w_rem_next;
    logic [DATA_W-1:0] w_quo_next;
    logic [DATA_W-1:0] w_quo_signed;
    logic [DATA_W-1:0] w_rem_signed;

    assign w_last  = (r_cnt == CNT_W'(DATA_W - 1));
    assign w_abs_a = A[DATA_W-1] ? (~A + 1'b1) : A;
    assign w_abs_b = B[DATA_W-1] ? (~B + 1'b1) : B;

    // Booth step: the add/subtract is one bit wider than the high word so that
    // subtracting the most negative multiplicand cannot overflow before the shift.
    always_comb begin
        w_booth_hi = {r_acc[ACC_W-1], r_acc[ACC_W-1 -: DATA_W]};
        w_mcand_x  = {r_mcand[DATA_W-1], r_mcand};
        case (r_acc[1:0])
            2'b01:   w_booth_sum = w_booth_hi + w_mcand_x;
            2'b10:   w_booth_sum = w_booth_hi - w_mcand_x;
            default: w_booth_sum = w_booth_hi;
        endcase
        w_acc_next = {w_booth_sum, r_acc[DATA_W:1]};
    end

    // Restoring-division step on magnitudes, followed by sign fix-up of the results.
    always_comb begin
        w_shift      = {r_rem, r_quo[DATA_W-1]};
        w_trial      = w_shift - {1'b0, r_divisor};
        w_fits       = ~w_trial[DATA_W];
        w_rem_next   = w_fits ? w_trial[DATA_W-1:0] : w_shift[DATA_W-1:0];
        w_quo_next   = {r_quo[DATA_W-2:0], w_fits};
        w_quo_signed = r_negq ? (~w_quo_next + 1'b1) : w_quo_next;
        w_rem_signed = r_negr ? (~w_rem_next + 1'b1) : w_rem_next;
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic: multiply wins over divide; divide by zero never leaves IDLE.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (MultStart) begin
                    w_next = S_MULT;
                end else if (DivStart && (B != '0)) begin
                    w_next = S_DIV;
                end
            end
            S_MULT:  if (w_last) w_next = S_DONE;
            S_DIV:   if (w_last) w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Datapath: operand capture, per-iteration update, HI/LO write on the final iteration.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt     <= '0;
            r_acc     <= '0;
            r_mcand   <= '0;
            r_rem     <= '0;
            r_quo     <= '0;
            r_divisor <= '0;
            r_negq    <= 1'b0;
            r_negr    <= 1'b0;
            r_hi      <= '0;
            r_lo      <= '0;
            r_divzero <= 1'b0;
        end else begin
            r_divzero <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (MultStart) begin
                        r_acc   <= {{DATA_W{1'b0}}, B, 1'b0};
                        r_mcand <= A;
                        r_cnt   <= '0;
                    end else if (DivStart) begin
                        if (B == '0) begin
                            r_divzero <= 1'b1;
                        end else begin
                            r_rem     <= '0;
                            r_quo     <= w_abs_a;
                            r_divisor <= w_abs_b;
                            r_negq    <= A[DATA_W-1] ^ B[DATA_W-1];
                            r_negr    <= A[DATA_W-1];
                            r_cnt     <= '0;
                        end
                    end
                end
                S_MULT: begin
                    r_acc <= w_acc_next;
                    r_cnt <= r_cnt + CNT_W'(1);
                    if (w_last) begin
                        r_hi <= w_acc_next[ACC_W-1 -: DATA_W];
                        r_lo <= w_acc_next[DATA_W:1];
                    end
                end
                S_DIV: begin
                    r_rem <= w_rem_next;
                    r_quo <= w_quo_next;
                    r_cnt <= r_cnt + CNT_W'(1);
                    if (w_last) begin
                        r_hi <= w_rem_signed;
                        r_lo <= w_quo_signed;
                    end
                end
                default: ;
            endcase
        end
    end

    assign HI      = r_hi;
    assign LO      = r_lo;
    assign Busy    = (r_state == S_MULT) || (r_state == S_DIV);
    assign Done    = (r_state == S_DONE);
    assign DivZero = r_divzero;

endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit: driver pushes expected results, monitor checks.
module tb_mult_div_unit;

    localparam int W = 32;

    logic         clk;
    logic         reset;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic         MultStart;
    logic         DivStart;
    logic [W-1:0] HI;
    logic [W-1:0] LO;
    logic         Busy;
    logic         Done;
    logic         DivZero;

    mult_div_unit #(.DATA_W(W)) dut (
        .clk      (clk),
        .reset    (reset),
        .A        (A),
        .B        (B),
        .MultStart(MultStart),
        .DivStart (DivStart),
        .HI       (HI),
        .LO       (LO),
        .Busy     (Busy),
        .Done     (Done),
        .DivZero  (DivZero)
    );

    typedef struct {
        bit           is_dz;
        logic [W-1:0] hi;
        logic [W-1:0] lo;
    } exp_t;

    exp_t         exp_q[$];
    logic [W-1:0] m_hi;
    logic [W-1:0] m_lo;
    int           busy_cnt;
    int           errors;
    int           checks;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: 64-bit signed arithmetic; SV division truncates toward zero
    // and the remainder follows the dividend's sign.
    function automatic void ref_op(input bit is_mult, input logic [W-1:0] a,
                                   input logic [W-1:0] b,
                                   output logic [W-1:0] hi, output logic [W-1:0] lo);
        longint       sa;
        longint       sb;
        logic [63:0]  v;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        if (is_mult) begin
            v  = sa * sb;
            hi = v[63:32];
            lo = v[31:0];
        end else begin
            v  = sa / sb;
            lo = v[31:0];
            v  = sa % sb;
            hi = v[31:0];
        end
    endfunction

    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input bit ms, input bit ds);
        int   n;
        exp_t e;
        n = 0;
        @(negedge clk);
        while ((Busy || Done) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            checks++;
            errors++;
            $display("FAIL idle_wait: got busy after %0d cycles expected idle", n);
        end
        A         = a;
        B         = b;
        MultStart = ms;
        DivStart  = ds;
        if (ms || ds) begin
            e.is_dz = (!ms && b == '0);
            e.hi    = '0;
            e.lo    = '0;
            if (!e.is_dz) ref_op(ms, a, b, e.hi, e.lo);
            exp_q.push_back(e);
        end
        @(posedge clk);
        #1;
        MultStart = 1'b0;
        DivStart  = 1'b0;
    endtask

    // Monitor: checks held HI/LO during Busy, and results on Done/DivZero.
    always @(negedge clk) begin
        exp_t e;
        if (!reset) begin
            busy_cnt = 0;
        end else begin
            if (Busy) begin
                busy_cnt++;
                chk("hold_hi", HI, m_hi);
                chk("hold_lo", LO, m_lo);
            end
            if (Done || DivZero) begin
                chk("done_dz_excl", {Done, DivZero}, Done ? 2'b10 : 2'b01);
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_event: got Done=%0b DivZero=%0b expected none", Done, DivZero);
                end else begin
                    e = exp_q.pop_front();
                    chk("event_kind", DivZero, e.is_dz);
                    if (Done) begin
                        chk("result_hi", HI, e.hi);
                        chk("result_lo", LO, e.lo);
                        chk("busy_cycles", busy_cnt, W);
                        m_hi = e.hi;
                        m_lo = e.lo;
                    end else begin
                        chk("dz_hi_kept", HI, m_hi);
                        chk("dz_lo_kept", LO, m_lo);
                        chk("dz_busy_cycles", busy_cnt, 0);
                    end
                end
                busy_cnt = 0;
            end
        end
    end

    initial begin
        int           n;
        int           mode;
        int           t;
        logic [W-1:0] ra;
        logic [W-1:0] rb;

        errors    = 0;
        checks    = 0;
        busy_cnt  = 0;
        m_hi      = '0;
        m_lo      = '0;
        reset     = 1'b0;
        A         = '0;
        B         = '0;
        MultStart = 1'b0;
        DivStart  = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_hi", HI, 0);
        chk("rst_lo", LO, 0);
        chk("rst_flags", {Busy, Done, DivZero}, 3'b000);
        @(negedge clk);
        reset = 1'b1;

        // Directed multiplies and divides.
        issue(32'd7,        32'hFFFFFFFD, 1'b1, 1'b0);
        issue(32'h80000000, 32'h80000000, 1'b1, 1'b0);
        issue(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b0);
        issue(32'hFFFFFFF9, 32'd2,        1'b0, 1'b1);
        issue(32'd7,        32'hFFFFFFFE, 1'b0, 1'b1);
        issue(32'h80000000, 32'hFFFFFFFF, 1'b0, 1'b1);
        issue(32'h12345678, 32'h9ABCDEF0, 1'b1, 1'b0);
        issue(32'd55,       32'd0,        1'b0, 1'b1);
        issue(32'd0,        32'd0,        1'b0, 1'b1);

        // Both starts together: multiply wins; a start during Busy is ignored.
        issue(32'd6, 32'd4, 1'b1, 1'b1);
        repeat (5) @(negedge clk);
        A         = 32'd99;
        B         = 32'd3;
        DivStart  = 1'b1;
        MultStart = 1'b1;
        @(posedge clk);
        #1;
        DivStart  = 1'b0;
        MultStart = 1'b0;

        // Randomized operations.
        for (int i = 0; i < 24; i++) begin
            mode = $urandom_range(0, 3);
            ra   = $urandom;
            rb   = $urandom;
            if ($urandom_range(0, 2) == 0) begin
                t  = $urandom_range(0, 40);
                ra = t - 20;
                t  = $urandom_range(0, 40);
                rb = t - 20;
            end
            if (mode <= 1) begin
                issue(ra, rb, 1'b1, 1'b0);
            end else if (mode == 2) begin
                if (rb == '0) rb = 32'd1;
                issue(ra, rb, 1'b0, 1'b1);
            end else begin
                issue(ra, 32'd0, 1'b0, 1'b1);
            end
        end

        // Asynchronous reset in the middle of a multiply.
        issue(32'd100, 32'd100, 1'b1, 1'b0);
        repeat (10) @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        chk("midrst_hi", HI, 0);
        chk("midrst_lo", LO, 0);
        chk("midrst_flags", {Busy, Done, DivZero}, 3'b000);
        exp_q.delete();
        m_hi = '0;
        m_lo = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        issue(32'hFFFFFFFB, 32'd9, 1'b1, 1'b0);
        issue(32'd100,      32'd7, 1'b0, 1'b1);

        // Drain outstanding expectations.
        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        chk("drain_empty", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
